// File: rtl/lemmings_world.sv
// lemmings_world: 1-D terrain height map and lemming position model that closes the loop around the walker FSM.
// Define LEMMINGS_WORLD_DIG_EN to let sustained digging remove terrain levels.
module lemmings_world #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DIG_CYCLES = 4,
    localparam int unsigned XW = $clog2(WIDTH),
    localparam int unsigned YW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          walk_left,
    input  logic          walk_right,
    input  logic          aaah,
    input  logic          digging,
    input  logic          dig_req,
    input  logic          cfg_we,
    input  logic [XW-1:0] cfg_col,
    input  logic [YW-1:0] cfg_h,
    input  logic          start,
    input  logic [XW-1:0] start_x,
    input  logic [YW-1:0] start_y,
    output logic          bump_left,
    output logic          bump_right,
    output logic          ground,
    output logic          dig,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic [7:0]    fall_len
);

    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);

    logic [YW-1:0] floor_q [WIDTH];
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic [7:0]    fall_len_q, fall_len_d;
    logic          bump_left_q, bump_left_d;
    logic          bump_right_q, bump_right_d;
    logic          dig_q;
    logic [YW-1:0] cur_floor, left_floor, right_floor;
    logic [XW-1:0] start_x_clamped;
    logic          dig_remove;

    assign cur_floor       = floor_q[pos_x_q];
    assign left_floor      = floor_q[pos_x_q - XW'(1)];
    assign right_floor     = floor_q[pos_x_q + XW'(1)];
    assign start_x_clamped = (32'(start_x) >= WIDTH) ? XMAX : start_x;

`ifdef LEMMINGS_WORLD_DIG_EN
    localparam int unsigned CW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

    logic [CW-1:0] dig_cnt_q, dig_cnt_d;

    // Counter restarts whenever digging is not the winning walker action.
    always_comb begin
        dig_cnt_d  = '0;
        dig_remove = 1'b0;
        if (!start && !aaah && digging) begin
            if (dig_cnt_q == CW'(DIG_CYCLES - 1)) begin
                dig_remove = (cur_floor != '0);
            end else begin
                dig_cnt_d = dig_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            dig_cnt_q <= '0;
        end else begin
            dig_cnt_q <= dig_cnt_d;
        end
    end
`else
    assign dig_remove = 1'b0;
`endif

    always_comb begin
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        fall_len_d   = fall_len_q;
        bump_left_d  = 1'b0;
        bump_right_d = 1'b0;
        if (start) begin
            pos_x_d    = start_x_clamped;
            pos_y_d    = start_y;
            fall_len_d = '0;
        end else if (aaah) begin
            if (pos_y_q > cur_floor) begin
                pos_y_d = pos_y_q - YW'(1);
                if (fall_len_q != '1) begin
                    fall_len_d = fall_len_q + 8'd1;
                end
            end
        end else if (!digging) begin
            if (walk_left) begin
                fall_len_d = '0;
                if (pos_x_q == '0 || left_floor > pos_y_q) begin
                    bump_left_d = 1'b1;
                end else begin
                    pos_x_d = pos_x_q - XW'(1);
                end
            end else if (walk_right) begin
                fall_len_d = '0;
                if (pos_x_q == XMAX || right_floor > pos_y_q) begin
                    bump_right_d = 1'b1;
                end else begin
                    pos_x_d = pos_x_q + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            fall_len_q   <= '0;
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;
            dig_q        <= 1'b0;
        end else begin
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            fall_len_q   <= fall_len_d;
            bump_left_q  <= bump_left_d;
            bump_right_q <= bump_right_d;
            dig_q        <= dig_req;
        end
    end

    // A configuration write to the column being dug overrides the removal.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                floor_q[i] <= '0;
            end
        end else begin
            if (dig_remove) begin
                floor_q[pos_x_q] <= cur_floor - YW'(1);
            end
            if (cfg_we) begin
                floor_q[cfg_col] <= cfg_h;
            end
        end
    end

    assign ground     = (pos_y_q <= cur_floor);
    assign bump_left  = bump_left_q;
    assign bump_right = bump_right_q;
    assign dig        = dig_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign fall_len   = fall_len_q;

endmodule

// File: doc/lemmings_world.md
# lemmings_world

Synthesizable terrain/environment model that drives the sense inputs of the lemming walker FSM (`bump_left`, `bump_right`, `ground`, `dig`) from that FSM's outputs (`walk_left`, `walk_right`, `aaah`, `digging`). It holds a 1-D column height map, tracks the lemming's column and altitude, and applies walking, falling and digging each clock. The walker and this block together form a closed loop for on-chip self-test and for the regression bench.

## Interface
- `WIDTH`, 16: number of terrain columns (≥2); `XW = $clog2(WIDTH)`.
- `DEPTH`, 32: number of altitude levels (≥2); `YW = $clog2(DEPTH)`.
- `DIG_CYCLES`, 4: consecutive `digging` cycles needed to remove one level from the current column (≥1).
- `clk` in 1: single clock, all state on rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `walk_left`, `walk_right`, `aaah`, `digging` in 1 each: walker outputs, at most one high per cycle.
- `dig_req` in 1: external dig command.
- `cfg_we` in 1: terrain write strobe.
- `cfg_col` in XW: column to write.
- `cfg_h` in YW: floor height to write.
- `start` in 1: place lemming.
- `start_x` in XW, `start_y` in YW: placement position.
- `bump_left`, `bump_right` out 1: registered one-cycle bump pulses.
- `ground` out 1: lemming stands on or below floor.
- `dig` out 1: `dig_req` delayed one cycle.
- `pos_x` out XW, `pos_y` out YW: current position.
- `fall_len` out 8: length of the current/last fall in cycles, saturating at 255.

## Operation
- State: `floor[0..WIDTH-1]` (YW bits each), `pos_x`, `pos_y`, `dig_cnt`, `fall_len`.
- `ground = (pos_y <= floor[pos_x])`, decoded from registers only (Moore).
- Per-cycle priority: `start` > motion. `cfg_we` is independent and always applies; motion in the same cycle uses the pre-write floor value.
- `start`: `pos_x<=start_x`, `pos_y<=start_y`, `dig_cnt<=0`, `fall_len<=0`, bumps cleared. `start_x ≥ WIDTH` clamps to WIDTH-1.
- `aaah`: if `pos_y > floor[pos_x]` then `pos_y<=pos_y-1`; `fall_len` increments, saturating at 255. `fall_len` clears on the first cycle `walk_left` or `walk_right` is high.
- `walk_left`: if `pos_x==0` or `floor[pos_x-1] > pos_y`, then `bump_left<=1` and `pos_x` holds; else `pos_x<=pos_x-1`. A step onto a lower column produces `ground=0` next cycle. Steps up of any height count as walls.
- `walk_right`: mirror of `walk_left`, with the edge at `pos_x==WIDTH-1`, using `bump_right`.
- `digging`: `dig_cnt` increments. At `dig_cnt==DIG_CYCLES-1`, if `floor[pos_x]>0` then `floor[pos_x]<=floor[pos_x]-1`; `dig_cnt<=0` in either case. At floor 0 (bedrock) nothing is removed.
- `dig_cnt` clears on any cycle `digging` is low.
- All walker outputs low (splat): position and terrain frozen; only `cfg_we`, `start` and `dig` remain active.
- Illegal input (more than one walker output high): priority `aaah` > `digging` > `walk_left` > `walk_right`.

## Timing
- Reset values: `floor[]=0`, `pos_x=0`, `pos_y=0`, `dig_cnt=0`, `fall_len=0`, `bump_left=0`, `bump_right=0`, `dig=0`, hence `ground=1`.
- `areset` mid-operation returns everything to reset values immediately; there is no partial terrain retention.
- Bump pulses are high for exactly the cycle after the blocked walk; they re-assert every cycle the walker keeps walking into the wall.
- `ground` reflects a dig-removed level one cycle after the removal edge; the walker then sees `ground=0` and falls.
- `dig` latency is 1 cycle; `cfg_we` takes effect in `floor` at the next edge.

## Configuration
- `LEMMINGS_WORLD_DIG_EN` defined: digging modifies terrain as described.
- Undefined: `dig_cnt` and the floor decrement are removed. `floor[]` changes only via `cfg_we`, and `digging` behaves as stationary (no position change).

## Test plan
- Reset, `cfg` floor[3..5]=2, `start` x=4 y=2, `walk_left` held -> x steps 4→3→2, `ground=0` on the cycle after reaching x=2.
- `start` x=0 y=0, `walk_left` -> `bump_left=1` for one cycle, x stays 0; same at x=15 with `walk_right`.
- Floor[6]=5, lemming at x=5 y=2, `walk_right` -> `bump_right` pulse, x=5 unchanged.
- Floor[2]=3, lemming x=2 y=3, `digging` for 8 cycles (DIG_CYCLES=4) -> floor[2]=1 after cycle 8; `ground=0` the cycle after the first removal.
- `start` y=31 over floor 0, `aaah` held -> y decrements to 0 in 31 cycles, `fall_len=31`, then `ground=1`; `fall_len` holds until walking resumes.
- Macro undefined: dig 8 cycles -> floor unchanged; assert `areset` mid-fall -> all outputs at reset values the same cycle.
